// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: control+data under valid/ready, optional 2-entry skid buffer, bubble counter.
// One-cycle latency; SKID=1 registers in_ready off skid occupancy, SKID=0 passes out_ready through.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_vld;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_vld;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              emit;

  always_comb begin
    if (SKID != 0) begin
      in_ready = ~skid_vld & ~flush;
    end else begin
      in_ready = (out_ready | ~main_vld) & ~flush;
    end
  end

  assign accept    = in_valid & in_ready;
  assign emit      = main_vld & out_ready;
  assign out_valid = main_vld;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  // Control is cleared whenever main goes empty so out_ctrl is always a bubble when invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld  <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
    end else if (flush) begin
      main_vld  <= 1'b0;
      main_ctrl <= '0;
    end else if (emit | ~main_vld) begin
      if ((SKID != 0) && skid_vld) begin
        main_vld  <= 1'b1;
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end else if (accept) begin
        main_vld  <= 1'b1;
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else begin
        main_vld  <= 1'b0;
        main_ctrl <= '0;
      end
    end
  end

  // Skid only fills when main is stalled; an emit always drains it into main.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_vld  <= 1'b0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      skid_vld <= 1'b0;
    end else if (SKID != 0) begin
      if (main_vld & ~emit & accept) begin
        skid_vld  <= 1'b1;
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end else if (emit) begin
        skid_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (~main_vld && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a no-skid instance share one stimulus stream,
// each checked every cycle against a queue model, plus directed literal expectations.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [7:0]  c;
    logic [95:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [7:0]  in_ctrl;
  logic [95:0] in_data;

  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_ctrl;
  logic [95:0] s_out_data;
  logic [3:0]  s_bubble_cnt;

  logic        n_in_ready, n_out_valid;
  logic [7:0]  n_out_ctrl;
  logic [95:0] n_out_data;
  logic [15:0] n_bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .bubble_cnt(s_bubble_cnt)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_ctrl(n_out_ctrl), .out_data(n_out_data),
    .bubble_cnt(n_bubble_cnt)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: each stage is a FIFO of beats (capacity 2 with skid, 1 without); the head is what is shown.
  beat_t       qs[$];
  beat_t       qn[$];
  int          ns_s = 0, ns_n = 0, cnt_s = 0, cnt_n = 0;
  logic [7:0]  hc_s = '0, hc_n = '0;
  logic [95:0] hd_s = '0, hd_n = '0;
  logic        started = 1'b0;
  logic        rdy_s, rdy_n;

  assign rdy_s = (ns_s < 2) && !flush;
  assign rdy_n = (out_ready || (ns_n == 0)) && !flush;

  always @(posedge clk) begin
    started <= 1'b1;
    if (reset) begin
      qs.delete();
      ns_s <= 0; cnt_s <= 0; hc_s <= '0; hd_s <= '0;
    end else begin
      if (ns_s == 0 && cnt_s < 15) cnt_s <= cnt_s + 1;
      if (ns_s > 0 && out_ready) void'(qs.pop_front());
      if (flush) qs.delete();
      else if (in_valid && rdy_s) qs.push_back({in_ctrl, in_data});
      ns_s <= qs.size();
      if (qs.size() > 0) begin
        hc_s <= qs[0].c;
        hd_s <= qs[0].d;
      end else begin
        hc_s <= '0;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      qn.delete();
      ns_n <= 0; cnt_n <= 0; hc_n <= '0; hd_n <= '0;
    end else begin
      if (ns_n == 0 && cnt_n < 65535) cnt_n <= cnt_n + 1;
      if (ns_n > 0 && out_ready) void'(qn.pop_front());
      if (flush) qn.delete();
      else if (in_valid && rdy_n) qn.push_back({in_ctrl, in_data});
      ns_n <= qn.size();
      if (qn.size() > 0) begin
        hc_n <= qn[0].c;
        hd_n <= qn[0].d;
      end else begin
        hc_n <= '0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("s_out_valid", 128'(s_out_valid), 128'(ns_s > 0));
      chk("s_out_ctrl", 128'(s_out_ctrl), 128'(hc_s));
      chk("s_out_data", 128'(s_out_data), 128'(hd_s));
      chk("s_in_ready", 128'(s_in_ready), 128'(rdy_s));
      chk("s_bubble_cnt", 128'(s_bubble_cnt), 128'(cnt_s));
      chk("n_out_valid", 128'(n_out_valid), 128'(ns_n > 0));
      chk("n_out_ctrl", 128'(n_out_ctrl), 128'(hc_n));
      chk("n_out_data", 128'(n_out_data), 128'(hd_n));
      chk("n_in_ready", 128'(n_in_ready), 128'(rdy_n));
      chk("n_bubble_cnt", 128'(n_bubble_cnt), 128'(cnt_n));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [95:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 8'h00, 96'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 128'(s_out_valid), 128'(0));
    chk("rst_out_ctrl", 128'(s_out_ctrl), 128'(0));
    chk("rst_out_data", 128'(s_out_data), 128'(0));
    chk("rst_in_ready", 128'(s_in_ready), 128'(1));
    chk("rst_bubble", 128'(s_bubble_cnt), 128'(0));

    // Idle: 4-bit counter saturates at 15, the 16-bit one keeps counting.
    repeat (20) tick();
    chk("cnt_sat", 128'(s_bubble_cnt), 128'(15));
    tick();
    chk("cnt_hold", 128'(s_bubble_cnt), 128'(15));
    chk("cnt_wide", 128'(n_bubble_cnt), 128'(21));

    // Stream of 10 beats, one cycle from accept to output.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(i), 96'(100 + i));
      tick();
      chk("stream_valid", 128'(s_out_valid), 128'(1));
      chk("stream_ctrl", 128'(s_out_ctrl), 128'(i));
      chk("stream_data", 128'(s_out_data), 128'(100 + i));
    end
    drive(1'b0, 8'h00, 96'h0);
    tick();
    chk("stream_end", 128'(s_out_valid), 128'(0));

    // Backpressure: two beats fit, the third waits.
    out_ready = 1'b0;
    drive(1'b1, 8'h10, 96'd200);
    tick();
    drive(1'b1, 8'h11, 96'd201);
    tick();
    drive(1'b1, 8'h12, 96'd202);
    #1;
    chk("bp_full", 128'(s_in_ready), 128'(0));
    tick();
    tick();
    chk("bp_still_full", 128'(s_in_ready), 128'(0));
    chk("bp_head", 128'(s_out_data), 128'(200));
    out_ready = 1'b1;
    #1;
    chk("bp_ready_registered", 128'(s_in_ready), 128'(0));
    tick();
    chk("bp_emit1", 128'(s_out_data), 128'(201));
    chk("bp_ready_back", 128'(s_in_ready), 128'(1));
    tick();
    chk("bp_emit2", 128'(s_out_data), 128'(202));
    chk("bp_emit2_ctrl", 128'(s_out_ctrl), 128'(8'h12));
    drive(1'b0, 8'h00, 96'h0);
    tick();
    chk("bp_drained", 128'(s_out_valid), 128'(0));

    // Flush with a stalled A5 beat: bubble, data held, new beat dropped.
    out_ready = 1'b0;
    drive(1'b1, 8'hA5, 96'hD00D);
    tick();
    flush = 1'b1;
    drive(1'b1, 8'h3C, 96'hBEEF);
    #1;
    chk("fl_in_ready", 128'(s_in_ready), 128'(0));
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 96'h0);
    chk("fl_valid", 128'(s_out_valid), 128'(0));
    chk("fl_ctrl", 128'(s_out_ctrl), 128'(0));
    chk("fl_data", 128'(s_out_data), 128'(96'hD00D));
    chk("fl_cnt", 128'(s_bubble_cnt), 128'(15));
    tick();
    chk("fl_dropped", 128'(s_out_valid), 128'(0));

    // Flush while the A5 beat is emitting.
    out_ready = 1'b1;
    drive(1'b1, 8'hA5, 96'hE1);
    tick();
    flush = 1'b1;
    drive(1'b1, 8'h3C, 96'hBEEF);
    #1;
    chk("fle_valid", 128'(s_out_valid), 128'(1));
    chk("fle_ctrl", 128'(s_out_ctrl), 128'(8'hA5));
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 96'h0);
    chk("fle_after", 128'(s_out_valid), 128'(0));
    chk("fle_data", 128'(s_out_data), 128'(96'hE1));

    // Back-to-back flush with both entries full.
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 96'h1);
    tick();
    drive(1'b1, 8'h02, 96'h2);
    tick();
    flush = 1'b1;
    drive(1'b1, 8'h03, 96'h3);
    tick();
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 96'h0);
    #1;
    chk("fl2_valid", 128'(s_out_valid), 128'(0));
    chk("fl2_ready", 128'(s_in_ready), 128'(1));
    chk("fl2_data", 128'(s_out_data), 128'(1));
    tick();

    // No-skid instance: in_ready follows out_ready combinationally.
    drive(1'b1, 8'h77, 96'h777);
    tick();
    drive(1'b0, 8'h00, 96'h0);
    #1;
    chk("comb_rdy0", 128'(n_in_ready), 128'(0));
    out_ready = 1'b1;
    #1;
    chk("comb_rdy1", 128'(n_in_ready), 128'(1));
    out_ready = 1'b0;
    #1;
    chk("comb_rdy0b", 128'(n_in_ready), 128'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("comb_empty_valid", 128'(n_out_valid), 128'(0));
    chk("comb_empty_rdy", 128'(n_in_ready), 128'(1));
    tick();

    // Reset (with flush) while two beats are buffered.
    drive(1'b1, 8'h41, 96'h41);
    tick();
    drive(1'b1, 8'h42, 96'h42);
    tick();
    drive(1'b0, 8'h00, 96'h0);
    #1;
    chk("mid_full", 128'(s_in_ready), 128'(0));
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    #1;
    chk("mid_valid", 128'(s_out_valid), 128'(0));
    chk("mid_ctrl", 128'(s_out_ctrl), 128'(0));
    chk("mid_data", 128'(s_out_data), 128'(0));
    chk("mid_ready", 128'(s_in_ready), 128'(1));
    chk("mid_cnt", 128'(s_bubble_cnt), 128'(0));
    tick();
    chk("mid_cnt1", 128'(s_bubble_cnt), 128'(1));
    chk("mid_no_emit", 128'(s_out_valid), 128'(0));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
